// File: rtl/pipe_sum_window_accum.sv
// Windowed accumulator for the pipelined adder output: sums WINDOW accepted samples
// with per-step signed saturation and hands each total off on a valid/ready port.
module pipe_sum_window_accum #(
   parameter int DATA_W = 32,
   parameter int WINDOW = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   input  logic                     clear,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_sat,
   input  logic                     out_ready,
   output logic [CNT_W-1:0]         win_count,
   output logic                     busy
);

   localparam int CW = $clog2(WINDOW + 1);
   localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                     state;
   logic signed [DATA_W-1:0]   acc;
   logic [CW-1:0]              cnt;
   logic                       sat;

   logic signed [DATA_W:0]     sum_ext;
   logic signed [DATA_W-1:0]   sum_clamp;
   logic                       ovf;

   // One extra bit holds any two-operand sum; overflow shows as the top two bits differing.
   always_comb begin
      sum_ext   = {acc[DATA_W-1], acc} + {in_data[DATA_W-1], in_data};
      ovf       = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
      sum_clamp = sum_ext[DATA_W-1:0];
      if (ovf)
         sum_clamp = sum_ext[DATA_W] ? SAT_MIN : SAT_MAX;
   end

   assign in_ready = (state == ACCUM);
   assign busy     = (cnt != '0) || (state == HOLD);

   // NOTE: every register below uses non-blocking assignment so all state updates
   // see the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         win_count <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (clear) begin
                  acc <= '0;
                  cnt <= '0;
                  sat <= 1'b0;
               end else if (in_valid) begin
                  if (cnt == LAST) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     out_data  <= sum_clamp;
                     out_sat   <= sat | ovf;
                     acc       <= '0;
                     cnt       <= '0;
                     sat       <= 1'b0;
                  end else begin
                     acc <= sum_clamp;
                     cnt <= cnt + 1'b1;
                     sat <= sat | ovf;
                  end
               end
            end
            HOLD: begin
               // An abort wins over a simultaneous handoff: the window is never counted.
               if (clear) begin
                  state     <= ACCUM;
                  out_valid <= 1'b0;
               end else if (out_ready) begin
                  state     <= ACCUM;
                  out_valid <= 1'b0;
                  win_count <= win_count + 1'b1;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_sum_window_accum.sv
// Self-checking bench for pipe_sum_window_accum: directed scenarios plus a randomized
// stream compared against a plain-arithmetic window-sum model.
module tb_pipe_sum_window_accum;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic signed [31:0] in_data = '0;
   logic               clear = 1'b0;
   logic               out_ready = 1'b0;

   logic               in_ready, out_valid, out_sat, busy;
   logic signed [31:0] out_data;
   logic [15:0]        win_count;

   logic               in_ready2, out_valid2, out_sat2, busy2;
   logic signed [31:0] out_data2;
   logic [1:0]         win_count2;

   int checks   = 0;
   int failures = 0;
   int exp_wc   = 0;

   always #5 clk = ~clk;

   pipe_sum_window_accum dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .clear(clear), .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat),
      .out_ready(out_ready), .win_count(win_count), .busy(busy)
   );

   pipe_sum_window_accum #(.DATA_W(32), .WINDOW(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
      .clear(clear), .out_valid(out_valid2), .out_data(out_data2), .out_sat(out_sat2),
      .out_ready(out_ready), .win_count(win_count2), .busy(busy2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: running sum clamped to the 32-bit signed range after every addition.
   function automatic void model_window(input logic signed [31:0] smp [4],
                                        output longint sum, output bit sat);
      sum = 0;
      sat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sum = sum + longint'(smp[i]);
         if (sum > SMAX) begin sum = SMAX; sat = 1'b1; end
         else if (sum < SMIN) begin sum = SMIN; sat = 1'b1; end
      end
   endfunction

   task automatic feed(input logic signed [31:0] d);
      int n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      if (!in_ready) begin
         failures++;
         $display("FAIL feed_timeout in_ready got=%0b required=1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_window(input string name, input logic signed [31:0] smp [4]);
      longint es;
      bit     esat;
      model_window(smp, es, esat);
      for (int i = 0; i < 4; i++) feed(smp[i]);
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL %s out_valid got=%b required=1", name, out_valid); end
      checks++;
      if (out_data !== 32'(es)) begin failures++; $display("FAIL %s out_data got=%0d required=%0d", name, out_data, es); end
      checks++;
      if (out_sat !== esat) begin failures++; $display("FAIL %s out_sat got=%b required=%b", name, out_sat, esat); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL %s hold_in_ready got=%b required=0", name, in_ready); end
      out_ready = 1'b1;
      step();
      exp_wc++;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s after_handoff out_valid/in_ready got=%b/%b required=0/1", name, out_valid, in_ready);
      end
      checks++;
      if (win_count !== 16'(exp_wc)) begin failures++; $display("FAIL %s win_count got=%0d required=%0d", name, win_count, exp_wc); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      exp_wc = 0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'sd0 || out_sat !== 1'b0 || win_count !== 16'd0
          || busy !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state got v=%b d=%0d s=%b wc=%0d busy=%b rdy=%b required 0 0 0 0 0 1",
                  out_valid, out_data, out_sat, win_count, busy, in_ready);
      end
   endtask

   task automatic test_basic();
      logic signed [31:0] w [4];
      out_ready = 1'b1;
      w = '{32'sd10, -32'sd3, 32'sd7, 32'sd1};
      test_window("basic", w);
   endtask

   task automatic test_saturation();
      logic signed [31:0] w [4];
      w = '{32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff};
      test_window("sat_max", w);
      w = '{32'sh80000000, -32'sd1, 32'sd0, 32'sd0};
      test_window("sat_min", w);
      w = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
      test_window("sat_no_carry", w);
      w = '{32'sh7fffffff, 32'sh7fffffff, 32'sh80000000, 32'sd0};
      test_window("sat_per_step", w);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) feed(32'sd1);
      in_valid = 1'b1;
      in_data  = 32'sd77;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'sd4 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d got v=%b d=%0d rdy=%b required 1 4 0", c, out_valid, out_data, in_ready);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      exp_wc++;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got rdy=%b v=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
      end
      checks++;
      if (win_count !== 16'(exp_wc)) begin failures++; $display("FAIL bp_win_count got=%0d required=%0d", win_count, exp_wc); end
   endtask

   task automatic test_clear();
      logic signed [31:0] w [4];
      out_ready = 1'b1;
      feed(32'sd5);
      feed(32'sd5);
      clear = 1'b1; in_valid = 1'b1; in_data = 32'sd9;
      step();
      clear = 1'b0; in_valid = 1'b0;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL clear_accum busy got=%b required=0", busy); end
      w = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
      test_window("clear_then_window", w);
      // Clear on the cycle that would complete a window drops it.
      for (int i = 0; i < 3; i++) feed(32'sd1);
      clear = 1'b1; in_valid = 1'b1; in_data = 32'sd1;
      step();
      clear = 1'b0; in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || win_count !== 16'(exp_wc)) begin
         failures++;
         $display("FAIL clear_complete got v=%b busy=%b wc=%0d required 0 0 %0d", out_valid, busy, win_count, exp_wc);
      end
      // Clear in HOLD wins over a simultaneous out_ready.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) feed(32'sd2);
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL clear_hold_pre out_valid got=%b required=1", out_valid); end
      clear = 1'b1; out_ready = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || win_count !== 16'(exp_wc)) begin
         failures++;
         $display("FAIL clear_hold got v=%b rdy=%b wc=%0d required 0 1 %0d", out_valid, in_ready, win_count, exp_wc);
      end
   endtask

   task automatic test_reset_in_hold();
      out_ready = 1'b0;
      feed(32'sd10); feed(-32'sd3); feed(32'sd7); feed(32'sd1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'sd15) begin
         failures++;
         $display("FAIL rst_hold_pre got v=%b d=%0d required 1 15", out_valid, out_data);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_wc = 0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'sd0 || win_count !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_hold got v=%b d=%0d wc=%0d busy=%b rdy=%b required 0 0 0 0 1",
                  out_valid, out_data, win_count, busy, in_ready);
      end
   endtask

   task automatic test_wrap();
      logic signed [31:0] w [4];
      int tab [5];
      tab = '{1, 2, 3, 0, 1};
      w = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
      for (int k = 0; k < 5; k++) begin
         test_window("wrap", w);
         checks++;
         if (win_count2 !== 2'(tab[k])) begin
            failures++;
            $display("FAIL wrap_cnt2 window=%0d got=%0d required=%0d", k, win_count2, tab[k]);
         end
      end
   endtask

   task automatic test_random();
      logic signed [31:0] pend [$];
      longint             exp_sum [$];
      bit                 exp_sat [$];
      logic signed [31:0] w [4];
      longint             s;
      bit                 st;
      int                 got = 0, fed = 0, cyc = 0;
      bit                 acc_now, hs;
      while (got < 40 && cyc < 4000) begin
         in_valid  = (fed < 160) && ($urandom_range(3) != 0);
         in_data   = 32'(int'($urandom_range(200)) - 100);
         out_ready = $urandom_range(1);
         acc_now   = in_valid && in_ready;
         hs        = out_valid && out_ready;
         if (hs) begin
            checks++;
            if (exp_sum.size() == 0) begin
               failures++;
               $display("FAIL rand_extra_window got=%0d required=none", out_data);
            end else begin
               s  = exp_sum.pop_front();
               st = exp_sat.pop_front();
               if (out_data !== 32'(s) || out_sat !== st) begin
                  failures++;
                  $display("FAIL rand_window idx=%0d got=%0d/%b required=%0d/%b", got, out_data, out_sat, s, st);
               end
            end
            got++;
            exp_wc++;
         end
         if (acc_now) begin
            pend.push_back(in_data);
            fed++;
            if (pend.size() == 4) begin
               for (int i = 0; i < 4; i++) w[i] = pend.pop_front();
               model_window(w, s, st);
               exp_sum.push_back(s);
               exp_sat.push_back(st);
            end
         end
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (got != 40 || exp_sum.size() != 0) begin
         failures++;
         $display("FAIL rand_count got=%0d pending=%0d required=40/0", got, exp_sum.size());
      end
      checks++;
      if (win_count !== 16'(exp_wc)) begin failures++; $display("FAIL rand_win_count got=%0d required=%0d", win_count, exp_wc); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_clear();
      test_reset_in_hold();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_sum_window_accum.md
Name: pipe_sum_window_accum

Overview:
- Downstream consumer of the three-operand pipelined adder output S (signed 32-bit).
- Accumulates WINDOW consecutive accepted samples with per-step signed saturation.
- Presents each window total on a valid/ready output port with a sticky saturation flag, for rate reduction before the cluster result collector.

Parameters:
- DATA_W, 32, width of input samples and of the accumulated result (two's complement).
- WINDOW, 4, samples per window; legal range 2..256.
- CNT_W, 16, width of the completed-window counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data carries a sample
- in_data  input  DATA_W  signed sample (adder S)
- in_ready  output  1  block can accept a sample this cycle
- clear  input  1  synchronous abort of current window
- out_valid  output  1  out_data/out_sat hold a completed window
- out_data  output  DATA_W  signed saturated window sum
- out_sat  output  1  saturation occurred at any step of this window
- out_ready  input  1  downstream accepts output
- win_count  output  CNT_W  number of windows handed off, wraps modulo 2^CNT_W
- busy  output  1  at least one sample of current window accepted, or output pending

Behaviour:
- Reset: one clock, synchronous, active-high; rst has priority over every other input.
- Reset values: state=ACCUM, acc=0, sample count=0, sat flag=0, out_valid=0, out_data=0, out_sat=0, win_count=0, busy=0. in_ready=1 in the cycle after reset.
- rst asserted in any state, including HOLD with output pending: next cycle all reset values apply and the pending output is discarded.
- FSM states:
  - ACCUM: in_ready=1. A sample is accepted on in_valid&&in_ready.
  - HOLD: in_ready=0, out_valid=1.
- Accept in ACCUM:
  - Sum acc+in_data at DATA_W+1 bits.
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Set the sticky sat flag if clamped.
  - Increment the count.
- Window completion: on the accept that brings the count to WINDOW, the next cycle has:
  - state=HOLD, out_valid=1, out_data=clamped sum, out_sat=sticky flag including this step;
  - acc, count and sat flag cleared internally.
- Latency: out_valid rises exactly 1 cycle after the final sample's accept edge.
- HOLD: out_data and out_sat stay stable while out_valid&&!out_ready. On out_valid&&out_ready the next cycle has:
  - out_valid=0, state=ACCUM, win_count+1 (wrap 2^CNT_W-1 -> 0).
- Throughput: at most WINDOW samples per WINDOW+1 cycles, since HOLD inserts at least one stall cycle.
- out_data is registered; in_ready is a function of state only and has no combinational path from out_ready.
- clear (rst inactive):
  - In ACCUM: acc, count and sat flag go to 0. A sample handshaking in the same cycle is dropped. A window that would complete in that cycle is dropped: no HOLD, win_count unchanged.
  - In HOLD: the pending output is discarded; out_valid=0, state=ACCUM, win_count unchanged. This holds even if out_ready=1 in the same cycle.
- busy=1 when count!=0 or state==HOLD.
- in_valid while in_ready=0: ignored; no sample is consumed and the upstream pipeline holds it.
- Saturation is per step, not final-only. Example: max + max + min saturates to max, then gives -1, with out_sat=1.

Test Plan:
- Reset, then samples 10,-3,7,1 on consecutive cycles with out_ready=1 -> out_valid pulse for 1 cycle, 1 cycle after the 4th accept, out_data=15, out_sat=0, win_count=1.
- Samples 2147483647 x4 -> out_data=2147483647, out_sat=1. Then -2147483648,-1,0,0 -> out_data=-2147483648, out_sat=1, and the sat flag does not carry over from the previous window.
- Window 1,1,1,1 with out_ready=0 for 5 cycles -> out_valid=1, out_data=4 stable, in_ready=0 throughout, in_valid samples not consumed. out_ready=1 -> next cycle in_ready=1, win_count increments once.
- Samples 5,5, then clear with in_valid=1,in_data=9, then 1,2,3,4 -> only one window, out_data=10, win_count=1. Also: clear during HOLD with out_ready=1 -> out_valid=0 next cycle, win_count unchanged.
- rst asserted during HOLD (out_data=15 pending) -> next cycle out_valid=0, out_data=0, win_count=0, busy=0, in_ready=1.
- Counter wrap with CNT_W=2: 5 complete windows -> win_count sequence 1,2,3,0,1. Random signed stream in [-100,100] over 40 windows with random out_ready -> out_data matches the reference-model window sums, no loss or duplication.
